wb_queue: RTL and testbench

Write-back queue sitting directly upstream of the register file's single write port. It accepts register write requests (destination index plus data) through a valid/ready handshake and buffers them in a small FIFO. It drains one entry per cycle into the register file's Reg_Write/Write_Register/Write_Data inputs. Optionally it forwards the newest pending data for the two read indices so decode sees writes that have not yet landed.

---
 rtl/wb_queue_pkg.sv | 13 +
 rtl/wb_queue_if.sv | 15 +
 rtl/wb_bypass_lookup.sv | 34 +++
 rtl/wb_queue.sv | 93 +++++++++
 tb/tb_wb_queue.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_queue_pkg.sv
// Shared types and default sizing for the write-back queue.
package wb_pkg;
    localparam int WB_WIDTH    = 32;
    localparam int WB_SELECTOR = 5;
    localparam int WB_DEPTH    = 4;

    localparam logic [WB_SELECTOR-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [WB_SELECTOR-1:0] idx;
        logic [WB_WIDTH-1:0]    data;
    } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// Write-request handshake between a producer (master) and the write-back queue (slave).
interface wb_queue_if
    import wb_pkg::*;
#(
    parameter int WIDTH    = WB_WIDTH,
    parameter int SELECTOR = WB_SELECTOR
);
    logic                wb_valid_i;
    logic                wb_ready_o;
    logic [SELECTOR-1:0] wb_reg_i;
    logic [WIDTH-1:0]    wb_data_i;

    modport master (output wb_valid_i, output wb_reg_i, output wb_data_i, input wb_ready_o);
    modport slave  (input wb_valid_i, input wb_reg_i, input wb_data_i, output wb_ready_o);
endinterface

// File: rtl/wb_bypass_lookup.sv
// Newest-first search of the queued entries for one register read index.
module wb_bypass_lookup
    import wb_pkg::*;
#(
    parameter  int WIDTH    = WB_WIDTH,
    parameter  int SELECTOR = WB_SELECTOR,
    parameter  int DEPTH    = WB_DEPTH,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int PTR_W    = IDX_W + 1
) (
    input  wb_entry_t           entries_i [DEPTH],
    input  logic [PTR_W-1:0]    head_i,
    input  logic [PTR_W-1:0]    level_i,
    input  logic [SELECTOR-1:0] lookup_i,
    output logic                hit_o,
    output logic [WIDTH-1:0]    hit_data_o
);
    // Walk oldest to newest so a later (newer) match overrides an earlier one.
    always_comb begin
        logic [IDX_W-1:0] slot;
        slot       = '0;
        hit_o      = 1'b0;
        hit_data_o = '0;
        if (lookup_i != SELECTOR'(ZERO_REG)) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot = head_i[IDX_W-1:0] + IDX_W'(i);
                if ((PTR_W'(i) < level_i) && (entries_i[slot].idx == lookup_i)) begin
                    hit_o      = 1'b1;
                    hit_data_o = entries_i[slot].data;
                end
            end
        end
    end
endmodule

// File: rtl/wb_queue.sv
// Write-back FIFO feeding the register file write port; bypass search
// compiled in only when WB_BYPASS_EN is defined.
module wb_queue
    import wb_pkg::*;
#(
    parameter  int WIDTH    = WB_WIDTH,
    parameter  int SELECTOR = WB_SELECTOR,
    parameter  int DEPTH    = WB_DEPTH,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int PTR_W    = IDX_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    wb_queue_if.slave           wb,
    input  logic                drain_hold_i,
    output logic                Reg_Write_o,
    output logic [SELECTOR-1:0] Write_Register_o,
    output logic [WIDTH-1:0]    Write_Data_o,
    input  logic [SELECTOR-1:0] lookup_reg_1_i,
    input  logic [SELECTOR-1:0] lookup_reg_2_i,
    output logic                hit_1_o,
    output logic                hit_2_o,
    output logic [WIDTH-1:0]    hit_data_1_o,
    output logic [WIDTH-1:0]    hit_data_2_o,
    output logic [PTR_W-1:0]    level_o
);
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        head_entry;
    logic             empty, full, enq, pop;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);
    // Register-0 writes finish the handshake but are never stored.
    assign enq   = wb.wb_valid_i && !full && (wb.wb_reg_i != SELECTOR'(ZERO_REG));
    assign pop   = !empty && !drain_hold_i;

    assign wb.wb_ready_o = !full;
    assign level_o       = tail_q - head_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop) head_d = head_q + PTR_W'(1);
        if (enq) tail_d = tail_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q[IDX_W-1:0]] <= '{idx: wb.wb_reg_i, data: wb.wb_data_i};
    end

    assign head_entry       = mem_q[head_q[IDX_W-1:0]];
    assign Reg_Write_o      = pop;
    assign Write_Register_o = empty ? '0 : head_entry.idx;
    assign Write_Data_o     = empty ? '0 : head_entry.data;

`ifdef WB_BYPASS_EN
    wb_bypass_lookup #(.WIDTH(WIDTH), .SELECTOR(SELECTOR), .DEPTH(DEPTH)) u_lookup_1 (
        .entries_i (mem_q),
        .head_i    (head_q),
        .level_i   (level_o),
        .lookup_i  (lookup_reg_1_i),
        .hit_o     (hit_1_o),
        .hit_data_o(hit_data_1_o)
    );
    wb_bypass_lookup #(.WIDTH(WIDTH), .SELECTOR(SELECTOR), .DEPTH(DEPTH)) u_lookup_2 (
        .entries_i (mem_q),
        .head_i    (head_q),
        .level_i   (level_o),
        .lookup_i  (lookup_reg_2_i),
        .hit_o     (hit_2_o),
        .hit_data_o(hit_data_2_o)
    );
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookup_reg_1_i, lookup_reg_2_i};
    assign hit_1_o       = 1'b0;
    assign hit_2_o       = 1'b0;
    assign hit_data_1_o  = '0;
    assign hit_data_2_o  = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Randomized and directed bench for wb_queue against a queue-based reference model.
module tb_wb_queue;
    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ment_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        drain_hold;
    logic        Reg_Write;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic [4:0]  lk1, lk2;
    logic        hit1, hit2;
    logic [31:0] hd1, hd2;
    logic [2:0]  level;

    int checks = 0;
    int passed = 0;
    ment_t mq[$];

    always #5 clk = ~clk;

    wb_queue_if #(.WIDTH(32), .SELECTOR(5)) wbif ();

    wb_queue #(.WIDTH(32), .SELECTOR(5), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .wb              (wbif),
        .drain_hold_i    (drain_hold),
        .Reg_Write_o     (Reg_Write),
        .Write_Register_o(Write_Register),
        .Write_Data_o    (Write_Data),
        .lookup_reg_1_i  (lk1),
        .lookup_reg_2_i  (lk2),
        .hit_1_o         (hit1),
        .hit_2_o         (hit2),
        .hit_data_1_o    (hd1),
        .hit_data_2_o    (hd2),
        .level_o         (level)
    );

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d, input logic h);
        wbif.wb_valid_i = v;
        wbif.wb_reg_i   = r;
        wbif.wb_data_i  = d;
        drain_hold      = h;
    endtask

    // Advance one edge and apply the same edge to the reference queue.
    task automatic tick();
        bit    push, popm;
        ment_t e;
        push = wbif.wb_valid_i && (mq.size() < DEPTH) && (wbif.wb_reg_i != 5'd0);
        popm = (mq.size() > 0) && !drain_hold;
        e.r  = wbif.wb_reg_i;
        e.d  = wbif.wb_data_i;
        @(posedge clk);
        #1;
        if (!rst) mq.delete();
        else begin
            if (popm) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
    endtask

    function automatic void model_hit(input logic [4:0] k, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (BYP && k != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].r == k) begin
                    h = 1'b1;
                    d = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h1, 1'b0);
        lk1 = 5'd3; lk2 = 5'd0;
        tick(); tick();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        checks++; if (wbif.wb_ready_o !== 1'b1) $display("FAIL reset_ready got %0b want 1", wbif.wb_ready_o); else passed++;
        checks++; if (Reg_Write !== 1'b0) $display("FAIL reset_regwrite got %0b want 0", Reg_Write); else passed++;
        checks++; if ({Write_Register, Write_Data} !== 37'd0) $display("FAIL reset_wr_wd got %0d/%h want 0/0", Write_Register, Write_Data); else passed++;
        checks++; if (level !== 3'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
        checks++; if ({hit1, hit2, hd1, hd2} !== 66'd0) $display("FAIL reset_hits got %0b%0b %h %h want zeros", hit1, hit2, hd1, hd2); else passed++;
    endtask

    task automatic test_single_write();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        checks++; if (Reg_Write !== 1'b1) $display("FAIL single_regwrite got %0b want 1", Reg_Write); else passed++;
        checks++; if (Write_Register !== 5'd5) $display("FAIL single_wr got %0d want 5", Write_Register); else passed++;
        checks++; if (Write_Data !== 32'hDEADBEEF) $display("FAIL single_wd got %h want deadbeef", Write_Data); else passed++;
        checks++; if (level !== 3'd1) $display("FAIL single_level1 got %0d want 1", level); else passed++;
        tick();
        checks++; if (level !== 3'd0 || Reg_Write !== 1'b0) $display("FAIL single_drained level %0d rw %0b want 0 0", level, Reg_Write); else passed++;
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(8'h11 * i), 1'b1);
            tick();
        end
        checks++; if (level !== 3'd4) $display("FAIL full_level got %0d want 4", level); else passed++;
        checks++; if (wbif.wb_ready_o !== 1'b0) $display("FAIL full_ready got %0b want 0", wbif.wb_ready_o); else passed++;
        drive(1'b1, 5'd9, 32'h99, 1'b1);
        tick();
        checks++; if (level !== 3'd4 || Write_Register !== 5'd1) $display("FAIL full_reject level %0d head %0d want 4 1", level, Write_Register); else passed++;
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (Reg_Write !== 1'b1 || Write_Register !== 5'(i) || Write_Data !== 32'(8'h11 * i))
                $display("FAIL full_drain%0d rw %0b reg %0d data %h want 1 %0d %h", i, Reg_Write, Write_Register, Write_Data, i, 32'(8'h11 * i));
            else passed++;
            tick();
        end
        checks++; if (level !== 3'd0) $display("FAIL full_empty got %0d want 0", level); else passed++;
    endtask

    task automatic test_reg0_discard();
        drive(1'b1, 5'd0, 32'h12345678, 1'b0);
        #1;
        checks++; if (wbif.wb_ready_o !== 1'b1) $display("FAIL reg0_ready got %0b want 1", wbif.wb_ready_o); else passed++;
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        checks++; if (level !== 3'd0 || Reg_Write !== 1'b0) $display("FAIL reg0_discard level %0d rw %0b want 0 0", level, Reg_Write); else passed++;
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'hA, 1'b1);
        tick();
        drive(1'b1, 5'd7, 32'hB, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1);
        lk1 = 5'd7; lk2 = 5'd8;
        #1;
        checks++; if (hit1 !== BYP) $display("FAIL bypass_hit1 got %0b want %0b", hit1, BYP); else passed++;
        checks++; if (hd1 !== (BYP ? 32'hB : 32'h0)) $display("FAIL bypass_data1 got %h want %h", hd1, BYP ? 32'hB : 32'h0); else passed++;
        checks++; if (hit2 !== 1'b0 || hd2 !== 32'h0) $display("FAIL bypass_miss2 got %0b %h want 0 0", hit2, hd2); else passed++;
        drain_hold = 1'b0;
        tick(); tick();
        lk1 = 5'd0; lk2 = 5'd0;
        checks++; if (level !== 3'd0) $display("FAIL bypass_drain level %0d want 0", level); else passed++;
    endtask

    task automatic test_stream();
        ment_t exp_e;
        for (int k = 0; k < 10; k++) begin
            exp_e.r = 5'((k % 7) + 1);
            exp_e.d = $urandom;
            drive(1'b1, exp_e.r, exp_e.d, 1'b0);
            tick();
            checks++;
            if (level > 3'd1 || Reg_Write !== 1'b1 || Write_Register !== exp_e.r || Write_Data !== exp_e.d)
                $display("FAIL stream%0d level %0d rw %0b reg %0d data %h want <=1 1 %0d %h", k, level, Reg_Write, Write_Register, Write_Data, exp_e.r, exp_e.d);
            else passed++;
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        checks++; if (level !== 3'd0) $display("FAIL stream_end level %0d want 0", level); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(3 + i), 32'hC0 + 32'(i), 1'b1);
            tick();
        end
        checks++; if (level !== 3'd3) $display("FAIL rstmid_pre level %0d want 3", level); else passed++;
        drive(1'b1, 5'd6, 32'hC6, 1'b0);
        lk1 = 5'd3; lk2 = 5'd5;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        checks++;
        if (level !== 3'd0 || Reg_Write !== 1'b0 || hit1 !== 1'b0 || hit2 !== 1'b0 || wbif.wb_ready_o !== 1'b1)
            $display("FAIL rstmid_post level %0d rw %0b hits %0b%0b rdy %0b want 0 0 00 1", level, Reg_Write, hit1, hit2, wbif.wb_ready_o);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (Reg_Write !== 1'b0) $display("FAIL rstmid_leak%0d rw %0b want 0", i, Reg_Write); else passed++;
            tick();
        end
        lk1 = 5'd0; lk2 = 5'd0;
    endtask

    task automatic test_random();
        logic        eh1, eh2;
        logic [31:0] ed1, ed2;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 4);
            lk1 = 5'($urandom_range(0, 7));
            lk2 = 5'($urandom_range(0, 7));
            #1;
            model_hit(lk1, eh1, ed1);
            model_hit(lk2, eh2, ed2);
            checks++;
            if (wbif.wb_ready_o !== (mq.size() < DEPTH) || level !== 3'(mq.size()))
                $display("FAIL rnd%0d_ctl rdy %0b level %0d want %0b %0d", c, wbif.wb_ready_o, level, mq.size() < DEPTH, mq.size());
            else passed++;
            checks++;
            if (Reg_Write !== (mq.size() > 0 && !drain_hold) ||
                Write_Register !== (mq.size() > 0 ? mq[0].r : 5'd0) || Write_Data !== (mq.size() > 0 ? mq[0].d : 32'd0))
                $display("FAIL rnd%0d_port rw %0b reg %0d data %h want %0b %0d %h", c, Reg_Write, Write_Register, Write_Data,
                         mq.size() > 0 && !drain_hold, mq.size() > 0 ? mq[0].r : 5'd0, mq.size() > 0 ? mq[0].d : 32'd0);
            else passed++;
            checks++;
            if (hit1 !== eh1 || hd1 !== ed1 || hit2 !== eh2 || hd2 !== ed2)
                $display("FAIL rnd%0d_bypass got %0b %h %0b %h want %0b %h %0b %h", c, hit1, hd1, hit2, hd2, eh1, ed1, eh2, ed2);
            else passed++;
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        lk1 = '0;
        lk2 = '0;
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        test_reset();
        test_single_write();
        test_fill_full();
        test_reg0_discard();
        test_bypass();
        test_stream();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
